// File: rtl/pe_requant_pkg.sv
// Shared constants and saturation helpers for the PE requantisation stage.
package pe_requant_pkg;

    localparam int ACC_W    = 32;
    localparam int SCALE_W  = 16;
    localparam int PROD_W   = ACC_W + SCALE_W;
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    localparam logic signed [PROD_W-1:0] PROD_I8_MAX = PROD_W'(INT8_MAX);
    localparam logic signed [PROD_W-1:0] PROD_I8_MIN = PROD_W'(INT8_MIN);

    // Clamp a 33-bit signed sum back into the signed 32-bit range.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
        if (v[ACC_W] != v[ACC_W-1])
            return v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return v[ACC_W-1:0];
    endfunction

    // Clamp a signed product-width value to int8.
    function automatic logic [7:0] sat_int8(input logic signed [PROD_W-1:0] v);
        if (v > PROD_I8_MAX)
            return 8'h7F;
        if (v < PROD_I8_MIN)
            return 8'h80;
        return v[7:0];
    endfunction

endpackage

// File: rtl/pe_requant_sync_fifo.sv
// Small synchronous FIFO with a registered head; write is dropped when full
// unless a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok, push_ok;

    // Next-state: pops on empty are ignored; a push on full succeeds only alongside a pop.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/pe_requant.sv
// Requantisation stage: bias add, fixed-point scale with rounding shift,
// optional ReLU, int8 saturation, 4:1 byte packing and an output FIFO.
module pe_requant #(
    parameter int ACC_W      = 32,
    parameter int SCALE_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic               acc_valid,
    input  logic [ACC_W-1:0]   bias,
    input  logic [SCALE_W-1:0] scale,
    input  logic [4:0]         shift,
    input  logic               relu_en,
    input  logic               flush,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow,
    output logic               busy
);
    import pe_requant_pkg::*;

    localparam int PW = ACC_W + SCALE_W;

    // Stage valids: [1]=sum, [2]=product, [3]=int8 byte.
    logic [3:1]              vld_q, vld_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic [7:0]              byte_q, byte_d;
    logic [1:0]              lane_q, lane_d;
    logic [23:0]             hold_q, hold_d;
    logic                    ovf_q, ovf_d;

    logic [ACC_W:0]          wide_sum;
    logic signed [PW-1:0]    rnd_add, rnd_sum, rnd, r;
    logic [31:0]             word;
    logic                    push, pop;
    logic                    fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Datapath: saturated bias add, scale multiply, round/shift/ReLU/saturate.
    always_comb begin
        vld_d    = {vld_q[2:1], acc_valid};

        wide_sum = {acc_in[ACC_W-1], acc_in} + {bias[ACC_W-1], bias};
        sum_d    = acc_valid ? sat_acc(wide_sum) : sum_q;

        prod_d   = vld_q[1]
                 ? $signed({{SCALE_W{sum_q[ACC_W-1]}}, sum_q}) * $signed({{ACC_W{1'b0}}, scale})
                 : prod_q;

        // |prod| < 2^47, so the rounding constant cannot overflow PW bits.
        rnd_add  = '0;
        rnd      = prod_q;
        if (shift != 5'd0) begin
            rnd_add = PW'(1) << (shift - 5'd1);
            rnd_sum = prod_q + rnd_add;
            rnd     = rnd_sum >>> shift;
        end else begin
            rnd_sum = prod_q;
        end
        r = (relu_en && rnd < 0) ? '0 : rnd;
        byte_d = vld_q[2] ? sat_int8(r) : byte_q;
    end

    // Packer: place the S3 byte, then push on a full word or on flush.
    always_comb begin
        word = {8'h00, hold_q};
        if (vld_q[3])
            word[{lane_q, 3'b000} +: 8] = byte_q;
        push   = (vld_q[3] && lane_q == 2'd3) || (flush && (vld_q[3] || lane_q != 2'd0));
        lane_d = lane_q;
        hold_d = hold_q;
        if (push) begin
            lane_d = 2'd0;
            hold_d = '0;
        end else if (vld_q[3]) begin
            lane_d = lane_q + 2'd1;
            hold_d = word[23:0];
        end
        pop   = out_ready && !fifo_empty;
        ovf_d = ovf_q || (push && fifo_full && !pop);
    end

    // Pipeline, packer and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            sum_q  <= '0;
            prod_q <= '0;
            byte_q <= '0;
            lane_q <= '0;
            hold_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            prod_q <= prod_d;
            byte_q <= byte_d;
            lane_q <= lane_d;
            hold_q <= hold_d;
            ovf_q  <= ovf_d;
        end
    end

    sync_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;
    assign busy      = (vld_q != '0) || (lane_q != 2'd0) || (fifo_count != '0);

endmodule
